// File: rtl/bitrev_reorder_pkg.sv
// bitrev_reorder_pkg: shared FFT defaults, read FSM states and the bit-reversal helper.
package bitrev_reorder_pkg;

    localparam int DATA_IN_WIDTH = 16;
    localparam int LOG_N_DEFAULT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    // Reverses the low `bits` bits of k (bits in 1..10); the result is right-aligned.
    function automatic logic [9:0] bitrev(input logic [9:0] k, input int bits);
        logic [9:0] r;
        r = {<<{k}};
        return r >> (10 - bits);
    endfunction

endpackage

// File: rtl/bitrev_reorder_dpram.sv
// bitrev_reorder_dpram: two-bank sample store, one synchronous write port and one registered read port.
// The bank select is the MSB of each address; the read register holds its value while re is low.
module bitrev_reorder_dpram #(
    parameter int W  = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_q, rd_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb rd_d = re ? mem[raddr] : rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else rd_q <= rd_d;
    end

    assign rdata = rd_q;

endmodule

// File: rtl/bitrev_reorder.sv
// bitrev_reorder: ping-pong reorder buffer turning bit-reversed FFT output frames into natural order.
// Define BITREV_REORDER_FRAME_MARK_EN to add do_first/do_last frame markers.
module bitrev_reorder
    import bitrev_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_IN_WIDTH,
    parameter int LOG_N      = LOG_N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  di_en,
    input  logic [DATA_WIDTH-1:0] di_re,
    input  logic [DATA_WIDTH-1:0] di_im,
    output logic                  do_en,
    output logic [DATA_WIDTH-1:0] do_re,
    output logic [DATA_WIDTH-1:0] do_im,
    output logic [LOG_N-1:0]      do_idx
`ifdef BITREV_REORDER_FRAME_MARK_EN
    ,
    output logic                  do_first,
    output logic                  do_last
`endif
);

    localparam logic [LOG_N-1:0] LAST = '1;

    logic [LOG_N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, do_idx_q, do_idx_d, waddr;
    logic wbank_q, wbank_d, rbank_q, rbank_d, do_en_q, do_en_d;
    logic [1:0] full_q, full_d, set_m, clr_m, avail;
    logic wr_done, rd, rd_last;
    rd_state_e state_q, state_d;
    logic [2*DATA_WIDTH-1:0] rdata;

    assign waddr = LOG_N'(bitrev(10'(wcnt_q), LOG_N));

    // A bank completing this cycle already counts as available, giving the 2-cycle frame latency.
    always_comb begin
        wr_done = di_en && wcnt_q == LAST;
        set_m   = wr_done ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;
        avail   = full_q | set_m;
        rd      = state_q == READ;
        rd_last = rd && rcnt_q == LAST;
        clr_m   = rd_last ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;
        full_d  = avail & ~clr_m;
        wcnt_d  = di_en ? wcnt_q + 1'b1 : wcnt_q;
        wbank_d = wbank_q ^ wr_done;
        rbank_d = rbank_q ^ rd_last;
        rcnt_d  = rd ? rcnt_q + 1'b1 : '0;
    end

    always_comb begin
        state_d = rd ? ((rd_last && !avail[~rbank_q]) ? IDLE : READ)
                     : (avail[rbank_q] ? READ : IDLE);
    end

    always_comb begin
        do_en_d  = rd;
        do_idx_d = rd ? rcnt_q : do_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            full_q   <= 2'b00;
            do_en_q  <= 1'b0;
            do_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            full_q   <= full_d;
            do_en_q  <= do_en_d;
            do_idx_q <= do_idx_d;
        end
    end

`ifdef BITREV_REORDER_FRAME_MARK_EN
    logic first_q, first_d, last_q, last_d;

    always_comb begin
        first_d = rd && rcnt_q == '0;
        last_d  = rd_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign do_first = first_q;
    assign do_last  = last_q;
`endif

    bitrev_reorder_dpram #(
        .W (2 * DATA_WIDTH),
        .AW(LOG_N + 1)
    ) u_dpram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (di_en),
        .waddr({wbank_q, waddr}),
        .wdata({di_re, di_im}),
        .re   (rd),
        .raddr({rbank_q, rcnt_q}),
        .rdata(rdata)
    );

    assign do_en  = do_en_q;
    assign do_idx = do_idx_q;
    assign do_re  = rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign do_im  = rdata[DATA_WIDTH-1:0];

endmodule
